// File: rtl/alu_sequencer.sv
// Instruction sequencer driving an external 4-bit combinational ALU.
// It owns a 4x4 register file and a load-immediate path, and returns results over a valid/ready handshake.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_cin,
  input  logic [3:0]  alu_f,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_data,
  output logic [1:0]  res_rd,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [3:0] regs [4];
  logic [1:0] rd_q;

  logic       f_li;
  logic [3:0] f_sel;
  logic       f_cin;
  logic [1:0] f_rd;
  logic [1:0] f_rs1;
  logic [1:0] f_rs2;
  logic [3:0] f_imm;

  assign f_li  = in_instr[15];
  assign f_sel = in_instr[14:11];
  assign f_cin = in_instr[10];
  assign f_rd  = in_instr[9:8];
  assign f_rs1 = in_instr[7:6];
  assign f_rs2 = in_instr[5:4];
  assign f_imm = in_instr[3:0];

  // in_ready is registered so it stays low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      alu_cin   <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      rd_q      <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            if (f_li) begin
              regs[f_rd] <= f_imm;
              res_data   <= f_imm;
              res_rd     <= f_rd;
              res_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              // Operands are captured here, so rs == rd reads the pre-write value.
              alu_a   <= regs[f_rs1];
              alu_b   <= regs[f_rs2];
              alu_s   <= f_sel;
              alu_cin <= f_cin;
              rd_q    <= f_rd;
              state   <= EXEC;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        EXEC: begin
          regs[rd_q] <= alu_f;
          res_data   <= alu_f;
          res_rd     <= rd_q;
          res_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
